// File: rtl/ram_responder.sv
// Word-addressed RAM model answering the datapath/cache request interface
// with a programmable BUSY latency and registered FREE/BUSY/ACCESS/ERROR status.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int unsigned IW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  ramstate_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic [1:0] type_q, type_d;
  word_t      load_q;
  word_t      mem_q [DEPTH];

  logic          req, err, differs, commit;
  logic [IW-1:0] idx;

  assign req     = ramREN | ramWEN;
  assign err     = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                   ({2'b00, ramaddr[31:2]} >= 32'(DEPTH));
  assign differs = (ramaddr != addr_q) | (ramstore != store_q) |
                   ({ramREN, ramWEN} != type_q);
  assign idx     = ramaddr[IW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    store_d = store_q;
    type_d  = type_q;
    commit  = 1'b0;
    case (state_q)
      FREE: begin
        if (req) begin
          if (err) begin
            state_d = ERROR;
          end else if (LAT == 0) begin
            state_d = ACCESS;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
            addr_d  = ramaddr;
            store_d = ramstore;
            type_d  = {ramREN, ramWEN};
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = FREE;
        end else if (differs) begin
          // A request that mutates into an illegal one is rejected rather than
          // relatched, so the array is never indexed with a bad address.
          if (err) begin
            state_d = ERROR;
          end else begin
            cnt_d   = LAT_M1;
            addr_d  = ramaddr;
            store_d = ramstore;
            type_d  = {ramREN, ramWEN};
          end
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ACCESS;
          commit  = 1'b1;
        end
      end
      ACCESS:  state_d = FREE;
      ERROR:   state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      cnt_q   <= '0;
      addr_q  <= '0;
      store_q <= '0;
      type_q  <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      type_q  <= type_d;
      if (commit && ramREN) begin
        load_q <= mem_q[idx];
      end
    end
  end

  // Array contents survive reset; only the commit is suppressed by RST.
  always_ff @(posedge CLK) begin
    if (!RST && commit && ramWEN) begin
      mem_q[idx] <= ramstore;
    end
  end

  assign ramstate = state_q;
  assign ramload  = load_q;

endmodule
